// File: rtl/video_line_capture_pkg.sv
// Shared definitions for the binarised-video capture path: geometry defaults, FSM encoding
// and the bundled sync/DE record carried through the input register stage.
package video_line_capture_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 11;
    localparam int unsigned DEF_HACTIVE     = 640;
    localparam int unsigned DEF_VACTIVE     = 480;
    localparam int unsigned DEF_PIXEL_WIDTH = 8;

    localparam int unsigned SYNC_WIDTH = 3;
    localparam int unsigned SYNC_DELAY = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StLine  = 2'd2,
        StDone  = 2'd3
    } cap_state_e;

    typedef struct packed {
        logic vsync;
        logic hsync;
        logic de;
    } sync_t;

endpackage

// File: rtl/video_line_capture_cycle_delay.sv
// Fixed-latency register pipeline used to align sync/DE with the registered pixel stream.
module video_line_capture_cycle_delay #(
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned DELAY      = 1
) (
    input  logic                  VCLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] iDATA,
    output logic [DATA_WIDTH-1:0] oDATA
);

    logic [DATA_WIDTH-1:0] pipe_q [DELAY];

    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= iDATA;
            for (int unsigned i = 1; i < DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign oDATA = pipe_q[DELAY-1];

endmodule

// File: rtl/video_line_capture.sv
// Binarises the camera luma stream, packs each active line into one word (bit index = H address)
// and hands completed lines to line memory over a WE/ACK handshake keyed by V address.
module video_line_capture
    import video_line_capture_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned HACTIVE     = DEF_HACTIVE,
    parameter int unsigned VACTIVE     = DEF_VACTIVE,
    parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
    input  logic                   VCLK,
    input  logic                   RST_N,
    input  logic                   iVSYNC,
    input  logic                   iHSYNC,
    input  logic                   iDE,
    input  logic [PIXEL_WIDTH-1:0] iPIXEL,
    input  logic [PIXEL_WIDTH-1:0] iTHRESHOLD,
    input  logic                   iCAPTURE_EN,
    output logic [ADDR_WIDTH-1:0]  oH_ADDR,
    output logic [ADDR_WIDTH-1:0]  oV_ADDR,
    output logic [HACTIVE-1:0]     oLINE_DATA,
    output logic [ADDR_WIDTH-1:0]  oLINE_ADDR,
    output logic                   oLINE_WE,
    input  logic                   iLINE_ACK,
    output logic                   oFRAME_DONE,
    output logic                   oOVERRUN
);

    localparam logic [ADDR_WIDTH-1:0] H_END  = ADDR_WIDTH'(HACTIVE);
    localparam logic [ADDR_WIDTH-1:0] V_END  = ADDR_WIDTH'(VACTIVE);
    localparam logic [ADDR_WIDTH-1:0] V_LAST = ADDR_WIDTH'(VACTIVE - 1);

    sync_t sync_in;
    sync_t sync_r;
    logic  hsync_unused;

    assign sync_in = '{vsync: iVSYNC, hsync: iHSYNC, de: iDE};

    video_line_capture_cycle_delay #(
        .DATA_WIDTH (SYNC_WIDTH),
        .DELAY      (SYNC_DELAY)
    ) u_sync_delay (
        .VCLK  (VCLK),
        .RST_N (RST_N),
        .iDATA (sync_in),
        .oDATA (sync_r)
    );

    // HSYNC is carried through the register stage but line boundaries come from DE alone.
    assign hsync_unused = sync_r.hsync;

    cap_state_e              state;
    logic                    pix_bit_r;
    logic                    vs_prev;
    logic                    de_prev;
    logic [ADDR_WIDTH-1:0]   h_cnt;
    logic [ADDR_WIDTH-1:0]   v_cnt;
    logic [HACTIVE-1:0]      shift_reg;
    logic [HACTIVE-1:0]      line_data;
    logic [ADDR_WIDTH-1:0]   line_addr;
    logic                    line_we;
    logic                    frame_done;
    logic                    overrun;

    logic pix_bit;
    logic vs_rise;
    logic de_fall;
    logic accept;

    assign pix_bit = (iPIXEL >= iTHRESHOLD);
    assign vs_rise = sync_r.vsync & ~vs_prev;
    assign de_fall = ~sync_r.de & de_prev;
    assign accept  = line_we & iLINE_ACK;

    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= StIdle;
            pix_bit_r  <= 1'b0;
            vs_prev    <= 1'b0;
            de_prev    <= 1'b0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            shift_reg  <= '0;
            line_data  <= '0;
            line_addr  <= '0;
            line_we    <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            pix_bit_r  <= pix_bit;
            vs_prev    <= sync_r.vsync;
            de_prev    <= sync_r.de;
            frame_done <= 1'b0;

            if (accept) begin
                line_we <= 1'b0;
            end

            if (!iCAPTURE_EN) begin
                state     <= StIdle;
                line_we   <= 1'b0;
                overrun   <= 1'b0;
                h_cnt     <= '0;
                v_cnt     <= '0;
                shift_reg <= '0;
            end else begin
                unique case (state)
                    StIdle: state <= StArmed;

                    StArmed: begin
                        if (vs_rise) begin
                            state     <= StLine;
                            h_cnt     <= '0;
                            v_cnt     <= '0;
                            shift_reg <= '0;
                        end
                    end

                    StLine: begin
                        if (accept && (line_addr == V_LAST)) begin
                            state      <= StDone;
                            frame_done <= 1'b1;
                        end else if (vs_rise) begin
                            // Restart the frame; a line already handed off still completes.
                            h_cnt     <= '0;
                            v_cnt     <= '0;
                            shift_reg <= '0;
                        end else if (de_fall) begin
                            if (v_cnt < V_END) begin
                                if (!line_we || iLINE_ACK) begin
                                    line_data <= shift_reg;
                                    line_addr <= v_cnt;
                                    line_we   <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                                v_cnt <= v_cnt + 1'b1;
                            end
                            h_cnt     <= '0;
                            shift_reg <= '0;
                        end else if (sync_r.de && (h_cnt < H_END)) begin
                            // Register is cleared per line, so setting bit h is an indexed write.
                            shift_reg <= shift_reg | (HACTIVE'(pix_bit_r) << h_cnt);
                            h_cnt     <= h_cnt + 1'b1;
                        end
                    end

                    StDone: state <= StIdle;

                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign oH_ADDR     = h_cnt;
    assign oV_ADDR     = v_cnt;
    assign oLINE_DATA  = line_data;
    assign oLINE_ADDR  = line_addr;
    assign oLINE_WE    = line_we;
    assign oFRAME_DONE = frame_done;
    assign oOVERRUN    = overrun;

endmodule

// File: tb/tb_video_line_capture.sv
// Self-checking bench for video_line_capture with an 8x4 frame and threshold 0x80.
module tb_video_line_capture;

    localparam int unsigned AW = 11;
    localparam int unsigned HA = 8;
    localparam int unsigned VA = 4;
    localparam int unsigned PW = 8;

    logic          VCLK        = 1'b0;
    logic          RST_N       = 1'b0;
    logic          iVSYNC      = 1'b0;
    logic          iHSYNC      = 1'b0;
    logic          iDE         = 1'b0;
    logic [PW-1:0] iPIXEL      = '0;
    logic [PW-1:0] iTHRESHOLD  = 8'h80;
    logic          iCAPTURE_EN = 1'b0;
    logic          iLINE_ACK   = 1'b0;
    logic [AW-1:0] oH_ADDR;
    logic [AW-1:0] oV_ADDR;
    logic [HA-1:0] oLINE_DATA;
    logic [AW-1:0] oLINE_ADDR;
    logic          oLINE_WE;
    logic          oFRAME_DONE;
    logic          oOVERRUN;

    video_line_capture #(
        .ADDR_WIDTH  (AW),
        .HACTIVE     (HA),
        .VACTIVE     (VA),
        .PIXEL_WIDTH (PW)
    ) dut (
        .VCLK        (VCLK),
        .RST_N       (RST_N),
        .iVSYNC      (iVSYNC),
        .iHSYNC      (iHSYNC),
        .iDE         (iDE),
        .iPIXEL      (iPIXEL),
        .iTHRESHOLD  (iTHRESHOLD),
        .iCAPTURE_EN (iCAPTURE_EN),
        .oH_ADDR     (oH_ADDR),
        .oV_ADDR     (oV_ADDR),
        .oLINE_DATA  (oLINE_DATA),
        .oLINE_ADDR  (oLINE_ADDR),
        .oLINE_WE    (oLINE_WE),
        .iLINE_ACK   (iLINE_ACK),
        .oFRAME_DONE (oFRAME_DONE),
        .oOVERRUN    (oOVERRUN)
    );

    always #5 VCLK = ~VCLK;

    typedef struct packed {
        logic [HA-1:0] data;
        logic [AW-1:0] addr;
    } acc_t;

    typedef struct {
        bit        vs;
        int        npix;
        logic [7:0] ev;
        logic [7:0] od;
        logic [7:0] exp_data;
        int        exp_addr;
        int        exp_h;
        int        exp_fd;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_pix_cyc = 0;
    int   last_lat = -1;
    int   we_rises = 0;
    int   fd_count = 0;
    logic we_prev = 1'b0;
    acc_t acc_q[$];

    always @(posedge VCLK) cyc <= cyc + 1;

    // Scoreboard: record every handshake transfer, WE rise latency and FRAME_DONE cycles.
    always @(negedge VCLK) begin
        if (oLINE_WE && iLINE_ACK) acc_q.push_back('{data: oLINE_DATA, addr: oLINE_ADDR});
        if (oLINE_WE && !we_prev) begin
            we_rises++;
            last_lat = cyc - last_pix_cyc;
        end
        we_prev = oLINE_WE;
        if (oFRAME_DONE) fd_count++;
    end

    task automatic tick();
        @(posedge VCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_acc(input string name, input logic [7:0] d, input int a);
        acc_t e;
        check({name, "_count"}, acc_q.size(), 1);
        if (acc_q.size() > 0) begin
            e = acc_q.pop_front();
            check({name, "_data"}, e.data, d);
            check({name, "_addr"}, e.addr, a);
        end
    endtask

    task automatic vsync_pulse();
        iVSYNC = 1'b1;
        tick();
        tick();
        iVSYNC = 1'b0;
        tick();
        tick();
    endtask

    // Pixel i is ev for even i, od for odd i. Optional ACK lands on the end-of-line cycle.
    task automatic send_line(input int n, input logic [7:0] ev, input logic [7:0] od,
                             input bit ack_at_fall, output int h_end);
        for (int i = 0; i < n; i++) begin
            iDE = 1'b1;
            iPIXEL = (i % 2 == 0) ? ev : od;
            last_pix_cyc = cyc;
            tick();
        end
        iDE = 1'b0;
        iPIXEL = '0;
        tick();
        h_end = int'(oH_ADDR);
        if (ack_at_fall) begin
            iLINE_ACK = 1'b1;
            tick();
            iLINE_ACK = 1'b0;
        end else begin
            tick();
        end
        repeat (5) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int   h_end;
        int   rises0;
        int   fd0;

        tbl[0] = '{1'b1, 8,  8'h00, 8'hFF, 8'hAA, 0, 8, 0};
        tbl[1] = '{1'b0, 8,  8'h00, 8'hFF, 8'hAA, 1, 8, 0};
        tbl[2] = '{1'b0, 8,  8'h00, 8'hFF, 8'hAA, 2, 8, 0};
        tbl[3] = '{1'b0, 8,  8'h00, 8'hFF, 8'hAA, 3, 8, 1};
        tbl[4] = '{1'b1, 8,  8'h80, 8'h7F, 8'h55, 0, 8, 1};
        tbl[5] = '{1'b0, 5,  8'hFF, 8'hFF, 8'h1F, 1, 5, 1};
        tbl[6] = '{1'b0, 10, 8'hFF, 8'hFF, 8'hFF, 2, 8, 1};
        tbl[7] = '{1'b0, 8,  8'h00, 8'hFF, 8'hAA, 3, 8, 2};

        repeat (3) tick();
        check("rst_h",    oH_ADDR, 0);
        check("rst_v",    oV_ADDR, 0);
        check("rst_data", oLINE_DATA, 0);
        check("rst_addr", oLINE_ADDR, 0);
        check("rst_we",   oLINE_WE, 0);
        check("rst_fd",   oFRAME_DONE, 0);
        check("rst_ovr",  oOVERRUN, 0);

        RST_N = 1'b1;
        iCAPTURE_EN = 1'b1;
        iLINE_ACK = 1'b1;
        repeat (3) tick();

        // Two frames with ACK tied high.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].vs) vsync_pulse();
            send_line(tbl[i].npix, tbl[i].ev, tbl[i].od, 1'b0, h_end);
            check($sformatf("t%0d_hend", i), h_end, tbl[i].exp_h);
            check($sformatf("t%0d_latency", i), last_lat, 3);
            expect_acc($sformatf("t%0d_line", i), tbl[i].exp_data, tbl[i].exp_addr);
            check($sformatf("t%0d_vaddr", i), oV_ADDR, tbl[i].exp_addr + 1);
            check($sformatf("t%0d_fdone", i), fd_count, tbl[i].exp_fd);
        end

        // Overrun: line 0 held, line 1 dropped, then line 2 lands at address 2.
        iLINE_ACK = 1'b0;
        fd0 = fd_count;
        vsync_pulse();
        send_line(8, 8'h00, 8'hFF, 1'b0, h_end);
        check("ovr_l0_we",   oLINE_WE, 1);
        check("ovr_l0_data", oLINE_DATA, 8'hAA);
        check("ovr_l0_flag", oOVERRUN, 0);
        send_line(8, 8'hFF, 8'hFF, 1'b0, h_end);
        check("ovr_l1_we",   oLINE_WE, 1);
        check("ovr_l1_data", oLINE_DATA, 8'hAA);
        check("ovr_l1_addr", oLINE_ADDR, 0);
        check("ovr_l1_flag", oOVERRUN, 1);
        check("ovr_l1_v",    oV_ADDR, 2);
        iLINE_ACK = 1'b1;
        tick();
        iLINE_ACK = 1'b0;
        tick();
        expect_acc("ovr_l0_acc", 8'hAA, 0);
        check("ovr_we_drop", oLINE_WE, 0);
        iLINE_ACK = 1'b1;
        send_line(8, 8'h80, 8'h7F, 1'b0, h_end);
        expect_acc("ovr_l2_acc", 8'h55, 2);
        check("ovr_sticky", oOVERRUN, 1);
        iLINE_ACK = 1'b0;
        send_line(5, 8'hFF, 8'hFF, 1'b0, h_end);
        check("l3_pend_we",   oLINE_WE, 1);
        check("l3_pend_addr", oLINE_ADDR, 3);

        // Disarm mid-frame drops the pending line and clears the overrun flag.
        iCAPTURE_EN = 1'b0;
        tick();
        check("dis_we",  oLINE_WE, 0);
        check("dis_ovr", oOVERRUN, 0);
        check("dis_v",   oV_ADDR, 0);
        iLINE_ACK = 1'b1;
        repeat (3) tick();
        check("dis_no_acc", acc_q.size(), 0);
        check("dis_no_fd",  fd_count, fd0);

        // ACK coinciding with end of line: the next line loads without overrun.
        iLINE_ACK = 1'b0;
        iCAPTURE_EN = 1'b1;
        repeat (3) tick();
        vsync_pulse();
        send_line(8, 8'h00, 8'hFF, 1'b0, h_end);
        send_line(5, 8'hFF, 8'hFF, 1'b1, h_end);
        expect_acc("same_l0_acc", 8'hAA, 0);
        check("same_we",   oLINE_WE, 1);
        check("same_data", oLINE_DATA, 8'h1F);
        check("same_addr", oLINE_ADDR, 1);
        check("same_ovr",  oOVERRUN, 0);
        iLINE_ACK = 1'b1;
        tick();
        expect_acc("same_l1_acc", 8'h1F, 1);

        // VSYNC rise in the middle of line 2 restarts numbering at 0.
        for (int i = 0; i < 3; i++) begin
            iDE = 1'b1;
            iPIXEL = 8'hFF;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            iDE = 1'b1;
            iPIXEL = 8'h00;
            iVSYNC = (i < 2);
            tick();
        end
        iDE = 1'b0;
        iVSYNC = 1'b0;
        repeat (8) tick();
        expect_acc("vs_restart", 8'h00, 0);
        check("vs_restart_v", oV_ADDR, 1);
        send_line(8, 8'h00, 8'hFF, 1'b0, h_end);
        expect_acc("vs_next", 8'hAA, 1);

        // Asynchronous reset while a line is pending and another is being sampled.
        iLINE_ACK = 1'b0;
        send_line(8, 8'h00, 8'hFF, 1'b0, h_end);
        check("arst_pre_we",   oLINE_WE, 1);
        check("arst_pre_addr", oLINE_ADDR, 2);
        iDE = 1'b1;
        iPIXEL = 8'hFF;
        tick();
        tick();
        RST_N = 1'b0;
        #1;
        check("arst_we",   oLINE_WE, 0);
        check("arst_data", oLINE_DATA, 0);
        check("arst_addr", oLINE_ADDR, 0);
        check("arst_h",    oH_ADDR, 0);
        check("arst_v",    oV_ADDR, 0);
        check("arst_fd",   oFRAME_DONE, 0);
        check("arst_ovr",  oOVERRUN, 0);
        iDE = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        iLINE_ACK = 1'b1;
        tick();
        tick();
        rises0 = we_rises;
        send_line(8, 8'h00, 8'hFF, 1'b0, h_end);
        check("arst_no_we",  we_rises, rises0);
        check("arst_no_acc", acc_q.size(), 0);
        vsync_pulse();
        send_line(8, 8'h80, 8'h7F, 1'b0, h_end);
        expect_acc("arst_rearm", 8'h55, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
